// File: rtl/zap_cp15_ctrl.sv
// CP15 system-control coprocessor: decodes MCR/MRC words handed over by predecode,
// moves data between the core register file and c1/c2/c3/c5/c6, and issues TLB/cache maintenance.
module zap_cp15_ctrl #(
  parameter logic [31:0] CP15_ID = 32'h4107_9260
) (
  input  logic        i_clk,
  input  logic        i_reset,

  input  logic        i_cp_dav,
  input  logic [31:0] i_cp_word,
  input  logic [4:0]  i_cpsr_mode,
  output logic        o_cp_done,

  output logic        o_reg_rd_en,
  output logic [3:0]  o_reg_rd_ndx,
  input  logic [31:0] i_reg_rd_data,

  output logic        o_reg_wr_en,
  output logic [3:0]  o_reg_wr_ndx,
  output logic [31:0] o_reg_wr_data,

  output logic [4:0]  o_reg_mode,

  output logic [31:0] o_ctrl,
  output logic [31:0] o_ttbr,
  output logic [31:0] o_dac,

  output logic        o_cache_inv,
  input  logic        i_cache_inv_done,
  output logic        o_tlb_inv,

  input  logic        i_fault_valid,
  input  logic [7:0]  i_fsr,
  input  logic [31:0] i_far
);

  localparam int unsigned XLEN    = 32;
  localparam int unsigned FSR_W   = 8;
  localparam int unsigned NDX_W   = 4;
  localparam logic [3:0]  CP_NUM  = 4'hF;
  localparam logic [3:0]  CRN_TLB = 4'd8;
  localparam logic [3:0]  CRN_INV = 4'd7;
  localparam logic [3:0]  RD_PC   = 4'd15;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    WR_CP,
    WR_REG,
    WAIT_INV,
    DONE
  } state_t;

  state_t            state;
  logic [NDX_W-1:0]  crn_q;
  logic [FSR_W-1:0]  fsr;
  logic [XLEN-1:0]   far;

  logic              is_cp15_xfer;
  logic              is_mcr;
  logic              is_mrc;
  logic [NDX_W-1:0]  word_crn;
  logic [NDX_W-1:0]  word_rd;
  logic [XLEN-1:0]   cp15_rd_data;

  // Opcode/CRm fields carry no meaning for this CP15 implementation.
  logic              unused_word_bits;
  assign unused_word_bits = ^{i_cp_word[31:28], i_cp_word[23:21], i_cp_word[7:5], i_cp_word[3:0]};

  // Register-transfer decode of the incoming word.
  always_comb begin
    word_crn     = i_cp_word[19:16];
    word_rd      = i_cp_word[15:12];
    is_cp15_xfer = (i_cp_word[27:24] == 4'b1110) && i_cp_word[4] && (i_cp_word[11:8] == CP_NUM);
    is_mcr       = is_cp15_xfer && !i_cp_word[20];
    is_mrc       = is_cp15_xfer &&  i_cp_word[20];
  end

  // CP15 read mux indexed by the incoming CRn.
  always_comb begin
    cp15_rd_data = '0;
    case (word_crn)
      4'd0:    cp15_rd_data = CP15_ID;
      4'd1:    cp15_rd_data = o_ctrl;
      4'd2:    cp15_rd_data = o_ttbr;
      4'd3:    cp15_rd_data = o_dac;
      4'd5:    cp15_rd_data = XLEN'({24'd0, fsr});
      4'd6:    cp15_rd_data = far;
      default: cp15_rd_data = '0;
    endcase
  end

  // Control FSM; every request output is a register that is high only in its own state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= IDLE;
      crn_q         <= '0;
      fsr           <= '0;
      far           <= '0;
      o_ctrl        <= '0;
      o_ttbr        <= '0;
      o_dac         <= '0;
      o_reg_mode    <= '0;
      o_reg_rd_en   <= 1'b0;
      o_reg_rd_ndx  <= '0;
      o_reg_wr_en   <= 1'b0;
      o_reg_wr_ndx  <= '0;
      o_reg_wr_data <= '0;
      o_tlb_inv     <= 1'b0;
      o_cache_inv   <= 1'b0;
      o_cp_done     <= 1'b0;
    end else begin
      o_reg_rd_en <= 1'b0;
      o_reg_wr_en <= 1'b0;
      o_tlb_inv   <= 1'b0;
      o_cache_inv <= 1'b0;
      o_cp_done   <= 1'b0;

      case (state)
        IDLE: begin
          if (i_cp_dav) begin
            crn_q      <= word_crn;
            o_reg_mode <= i_cpsr_mode;
            if (is_mcr) begin
              state        <= RD_REQ;
              o_reg_rd_en  <= 1'b1;
              o_reg_rd_ndx <= word_rd;
            end else if (is_mrc) begin
              // Writes to the PC are dropped; the handshake still completes.
              state         <= WR_REG;
              o_reg_wr_en   <= (word_rd != RD_PC);
              o_reg_wr_ndx  <= word_rd;
              o_reg_wr_data <= cp15_rd_data;
            end else begin
              state     <= DONE;
              o_cp_done <= 1'b1;
            end
          end
        end

        RD_REQ: begin
          state     <= WR_CP;
          o_tlb_inv <= (crn_q == CRN_TLB);
        end

        WR_CP: begin
          case (crn_q)
            4'd1:    o_ctrl <= i_reg_rd_data;
            4'd2:    o_ttbr <= i_reg_rd_data;
            4'd3:    o_dac  <= i_reg_rd_data;
            4'd5:    fsr    <= i_reg_rd_data[FSR_W-1:0];
            4'd6:    far    <= i_reg_rd_data;
            default: ;
          endcase
          if (crn_q == CRN_INV) begin
            state       <= WAIT_INV;
            o_cache_inv <= 1'b1;
          end else begin
            state     <= DONE;
            o_cp_done <= 1'b1;
          end
        end

        WR_REG: begin
          state     <= DONE;
          o_cp_done <= 1'b1;
        end

        WAIT_INV: begin
          if (i_cache_inv_done) begin
            state     <= DONE;
            o_cp_done <= 1'b1;
          end else begin
            o_cache_inv <= 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase

      // MMU fault capture overrides a coincident software write to c5/c6.
      if (i_fault_valid) begin
        fsr <= i_fsr;
        far <= i_far;
      end
    end
  end

endmodule

// File: tb/tb_zap_cp15_ctrl.sv
// Scoreboard bench for zap_cp15_ctrl: directed MCR/MRC/other words, expected port events
// are queued with their cycle and a negedge monitor pops and compares them.
module tb_zap_cp15_ctrl;

  localparam logic [31:0] ID = 32'h4107_9260;
  localparam int EV_RD = 0, EV_WR = 1, EV_TLB = 2, EV_INV = 3, EV_DONE = 4;

  typedef struct {
    int          kind;
    int          cyc;
    logic [3:0]  ndx;
    logic [31:0] data;
  } ev_t;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_cp_dav;
  logic [31:0] i_cp_word;
  logic [4:0]  i_cpsr_mode;
  logic        o_cp_done;
  logic        o_reg_rd_en;
  logic [3:0]  o_reg_rd_ndx;
  logic [31:0] i_reg_rd_data;
  logic        o_reg_wr_en;
  logic [3:0]  o_reg_wr_ndx;
  logic [31:0] o_reg_wr_data;
  logic [4:0]  o_reg_mode;
  logic [31:0] o_ctrl, o_ttbr, o_dac;
  logic        o_cache_inv;
  logic        i_cache_inv_done;
  logic        o_tlb_inv;
  logic        i_fault_valid;
  logic [7:0]  i_fsr;
  logic [31:0] i_far;

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  ev_t q[$];

  zap_cp15_ctrl dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_cp_dav(i_cp_dav), .i_cp_word(i_cp_word), .i_cpsr_mode(i_cpsr_mode),
    .o_cp_done(o_cp_done),
    .o_reg_rd_en(o_reg_rd_en), .o_reg_rd_ndx(o_reg_rd_ndx), .i_reg_rd_data(i_reg_rd_data),
    .o_reg_wr_en(o_reg_wr_en), .o_reg_wr_ndx(o_reg_wr_ndx), .o_reg_wr_data(o_reg_wr_data),
    .o_reg_mode(o_reg_mode),
    .o_ctrl(o_ctrl), .o_ttbr(o_ttbr), .o_dac(o_dac),
    .o_cache_inv(o_cache_inv), .i_cache_inv_done(i_cache_inv_done), .o_tlb_inv(o_tlb_inv),
    .i_fault_valid(i_fault_valid), .i_fsr(i_fsr), .i_far(i_far)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  function automatic logic [31:0] rf_val(input logic [3:0] n);
    return (n == 4'd3) ? 32'h0000_4000 : (32'hA5A5_0000 | 32'(n));
  endfunction

  // Register file responder: data valid the cycle after the read request.
  always @(posedge i_clk)
    i_reg_rd_data <= o_reg_rd_en ? rf_val(o_reg_rd_ndx) : 32'hBAD0_BAD0;

  function automatic logic [31:0] cpw(input logic l, input logic [3:0] crn,
                                      input logic [3:0] rd, input logic [3:0] cp);
    return {4'hE, 4'b1110, 3'd0, l, crn, rd, cp, 3'd0, 1'b1, 4'd0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input int c, input logic [3:0] ndx, input logic [31:0] data);
    ev_t e;
    e.kind = kind; e.cyc = c; e.ndx = ndx; e.data = data;
    q.push_back(e);
  endtask

  task automatic check_evt(input int kind, input logic [3:0] ndx, input logic [31:0] data);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL evt_unexpected: got kind %0d at cycle %0d expected none", kind, cyc);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.ndx !== ndx || e.data !== data) begin
        errors++;
        $display("FAIL evt: got kind %0d cyc %0d ndx %0d data %h expected kind %0d cyc %0d ndx %0d data %h",
                 kind, cyc, ndx, data, e.kind, e.cyc, e.ndx, e.data);
      end
    end
  endtask

  // Monitor: every asserted request output must match the head of the queue.
  always @(negedge i_clk) begin
    if (o_reg_rd_en) check_evt(EV_RD, o_reg_rd_ndx, 32'({27'd0, o_reg_mode}));
    if (o_reg_wr_en) check_evt(EV_WR, o_reg_wr_ndx, o_reg_wr_data);
    if (o_tlb_inv)   check_evt(EV_TLB, 4'd0, 32'd0);
    if (o_cache_inv) check_evt(EV_INV, 4'd0, 32'd0);
    if (o_cp_done)   check_evt(EV_DONE, 4'd0, 32'd0);
  end

  // Issue one word (called #1 after an edge while IDLE); returns #1 after the edge following done.
  task automatic run_op(input logic [31:0] w, input int inv_at, input int fault_at);
    int  acc;
    bit  seen;
    acc  = cyc + 1;
    seen = 1'b0;
    i_cp_dav  = 1'b1;
    i_cp_word = w;
    for (int k = 0; k < 40; k++) begin
      @(posedge i_clk); #1;
      i_cache_inv_done = (inv_at >= 0) && (cyc == acc + inv_at);
      i_fault_valid    = (fault_at >= 0) && (cyc == acc + fault_at);
      if (o_cp_done) begin
        seen = 1'b1;
        break;
      end
    end
    i_cp_dav = 1'b0;
    i_cache_inv_done = 1'b0;
    i_fault_valid = 1'b0;
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no o_cp_done expected done for word %h", w);
    end
    @(posedge i_clk); #1;
  endtask

  int a;

  initial begin
    i_reset = 1'b1; i_cp_dav = 1'b0; i_cp_word = '0; i_cpsr_mode = 5'h13;
    i_cache_inv_done = 1'b0; i_fault_valid = 1'b0; i_fsr = 8'h05; i_far = 32'hDEAD_0000;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_ctrl", o_ctrl, 32'd0);
    chk("rst_ttbr", o_ttbr, 32'd0);
    chk("rst_dac", o_dac, 32'd0);
    chk("rst_mode", 32'(o_reg_mode), 32'd0);
    chk("rst_reqs", 32'({o_reg_rd_en, o_reg_wr_en, o_tlb_inv, o_cache_inv, o_cp_done}), 32'd0);
    i_reset = 1'b0;
    @(posedge i_clk); #1;

    // MCR c2 from R3
    a = cyc + 1; push(EV_RD, a, 4'd3, 32'h13); push(EV_DONE, a + 2, 4'd0, 32'd0);
    run_op(cpw(1'b0, 4'd2, 4'd3, 4'hF), -1, -1);
    chk("ttbr", o_ttbr, 32'h0000_4000);

    // MCR c1 from R5, c3 from R6 (mode SYS)
    i_cpsr_mode = 5'h1F;
    a = cyc + 1; push(EV_RD, a, 4'd5, 32'h1F); push(EV_DONE, a + 2, 4'd0, 32'd0);
    run_op(cpw(1'b0, 4'd1, 4'd5, 4'hF), -1, -1);
    chk("ctrl", o_ctrl, 32'hA5A5_0005);
    a = cyc + 1; push(EV_RD, a, 4'd6, 32'h1F); push(EV_DONE, a + 2, 4'd0, 32'd0);
    run_op(cpw(1'b0, 4'd3, 4'd6, 4'hF), -1, -1);
    chk("dac", o_dac, 32'hA5A5_0006);

    // MRC c0 -> R1, c2 -> R4, c0 -> R15 (suppressed), c4 -> R2 (reads zero)
    a = cyc + 1; push(EV_WR, a, 4'd1, ID); push(EV_DONE, a + 1, 4'd0, 32'd0);
    run_op(cpw(1'b1, 4'd0, 4'd1, 4'hF), -1, -1);
    a = cyc + 1; push(EV_WR, a, 4'd4, 32'h0000_4000); push(EV_DONE, a + 1, 4'd0, 32'd0);
    run_op(cpw(1'b1, 4'd2, 4'd4, 4'hF), -1, -1);
    a = cyc + 1; push(EV_DONE, a + 1, 4'd0, 32'd0);
    run_op(cpw(1'b1, 4'd0, 4'd15, 4'hF), -1, -1);
    a = cyc + 1; push(EV_WR, a, 4'd2, 32'd0); push(EV_DONE, a + 1, 4'd0, 32'd0);
    run_op(cpw(1'b1, 4'd4, 4'd2, 4'hF), -1, -1);

    // MCR c8: TLB pulse in WR_CP
    a = cyc + 1; push(EV_RD, a, 4'd0, 32'h1F); push(EV_TLB, a + 1, 4'd0, 32'd0);
    push(EV_DONE, a + 2, 4'd0, 32'd0);
    run_op(cpw(1'b0, 4'd8, 4'd0, 4'hF), -1, -1);

    // MCR c7: cache_inv held 5 cycles until ack, done next cycle
    a = cyc + 1; push(EV_RD, a, 4'd0, 32'h1F);
    for (int k = 2; k <= 6; k++) push(EV_INV, a + k, 4'd0, 32'd0);
    push(EV_DONE, a + 7, 4'd0, 32'd0);
    run_op(cpw(1'b0, 4'd7, 4'd0, 4'hF), 6, -1);

    // MCR c5 from R8 writes fsr low byte, read back via MRC
    a = cyc + 1; push(EV_RD, a, 4'd8, 32'h1F); push(EV_DONE, a + 2, 4'd0, 32'd0);
    run_op(cpw(1'b0, 4'd5, 4'd8, 4'hF), -1, -1);
    a = cyc + 1; push(EV_WR, a, 4'd9, 32'h0000_0008); push(EV_DONE, a + 1, 4'd0, 32'd0);
    run_op(cpw(1'b1, 4'd5, 4'd9, 4'hF), -1, -1);

    // MCR c6 from R7 with coincident fault: fault wins
    a = cyc + 1; push(EV_RD, a, 4'd7, 32'h1F); push(EV_DONE, a + 2, 4'd0, 32'd0);
    run_op(cpw(1'b0, 4'd6, 4'd7, 4'hF), -1, 1);
    a = cyc + 1; push(EV_WR, a, 4'd9, 32'hDEAD_0000); push(EV_DONE, a + 1, 4'd0, 32'd0);
    run_op(cpw(1'b1, 4'd6, 4'd9, 4'hF), -1, -1);
    a = cyc + 1; push(EV_WR, a, 4'd10, 32'h0000_0005); push(EV_DONE, a + 1, 4'd0, 32'd0);
    run_op(cpw(1'b1, 4'd5, 4'd10, 4'hF), -1, -1);

    // CDP and coprocessor 14 words: done one cycle after accept, nothing else
    a = cyc + 1; push(EV_DONE, a, 4'd0, 32'd0);
    run_op(32'hEE01_2F00, -1, -1);
    a = cyc + 1; push(EV_DONE, a, 4'd0, 32'd0);
    run_op(cpw(1'b1, 4'd0, 4'd1, 4'hE), -1, -1);
    chk("ctrl_kept", o_ctrl, 32'hA5A5_0005);

    // Reset while in WAIT_INV
    a = cyc + 1; push(EV_RD, a, 4'd1, 32'h1F);
    push(EV_INV, a + 2, 4'd0, 32'd0); push(EV_INV, a + 3, 4'd0, 32'd0);
    i_cp_dav = 1'b1; i_cp_word = cpw(1'b0, 4'd7, 4'd1, 4'hF);
    repeat (4) begin @(posedge i_clk); #1; end
    i_reset = 1'b1; i_cp_dav = 1'b0;
    @(posedge i_clk); #1;
    chk("rstinv_cache_inv", 32'(o_cache_inv), 32'd0);
    chk("rstinv_done", 32'(o_cp_done), 32'd0);
    chk("rstinv_ctrl", o_ctrl, 32'd0);
    i_reset = 1'b0;
    @(posedge i_clk); #1;
    a = cyc + 1; push(EV_WR, a, 4'd2, 32'd0); push(EV_DONE, a + 1, 4'd0, 32'd0);
    run_op(cpw(1'b1, 4'd1, 4'd2, 4'hF), -1, -1);

    repeat (3) @(posedge i_clk);
    #1;
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/zap_cp15_ctrl.md
ZAP_CP15_CTRL -- requirements
Module: zap_cp15_ctrl

Interface
REQ-001 SHALL have parameter CP15_ID, default 32'h4107_9260, value returned for CRn=0 reads.
REQ-002 SHALL have i_clk  input  1  clock; all state changes on rising edge.
REQ-003 SHALL have i_reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have i_cp_dav  input  1  coprocessor request valid from predecode coprocessor stage; held high until o_cp_done.
REQ-005 SHALL have i_cp_word  input  32  full coprocessor instruction, stable while i_cp_dav high.
REQ-006 SHALL have i_cpsr_mode  input  5  current CPU mode, sampled at acceptance.
REQ-007 SHALL have o_cp_done  output  1  single-cycle completion pulse back to predecode.
REQ-008 SHALL have o_reg_rd_en, o_reg_rd_ndx  output  1/4  core register read request, architectural index.
REQ-009 SHALL have i_reg_rd_data  input  32  read data, valid exactly one cycle after o_reg_rd_en.
REQ-010 SHALL have o_reg_wr_en, o_reg_wr_ndx, o_reg_wr_data  output  1/4/32  core register write.
REQ-011 SHALL have o_reg_mode  output  5  latched mode for bank translation of both register ports.
REQ-012 SHALL have o_ctrl, o_ttbr, o_dac  output  32 each  CP15 c1, c2, c3 contents.
REQ-013 SHALL have o_cache_inv  output  1  cache clean/invalidate request; i_cache_inv_done  input  1  acknowledge.
REQ-014 SHALL have o_tlb_inv  output  1  one-cycle TLB invalidate pulse.
REQ-015 SHALL have i_fault_valid, i_fsr, i_far  input  1/8/32  MMU fault capture.

Function
REQ-016 SHALL implement states IDLE, RD_REQ, WR_CP, WR_REG, WAIT_INV, DONE.
REQ-017 SHALL accept a request only in IDLE with i_cp_dav=1, latching i_cp_word and i_cpsr_mode; i_cp_dav ignored in all other states.
REQ-018 SHALL classify MCR as word[27:24]=4'b1110, word[20]=0, word[4]=1, word[11:8]=4'hF; MRC identical with word[20]=1.
REQ-019 SHALL send any other accepted word (CDP, LDC, STC, non-CP15) directly IDLE->DONE with no register or CP15 side effect.
REQ-020 MCR: IDLE->RD_REQ (o_reg_rd_en=1, o_reg_rd_ndx=word[15:12]) ->WR_CP (capture i_reg_rd_data into CRn=word[19:16]) ->DONE, or ->WAIT_INV if CRn=7.
REQ-021 MRC: IDLE->WR_REG (o_reg_wr_en=1, o_reg_wr_ndx=word[15:12], o_reg_wr_data=CP15[CRn]) ->DONE.
REQ-022 MRC with Rd=15 SHALL suppress o_reg_wr_en; transition unchanged.
REQ-023 Readable CRn: 0=CP15_ID, 1=ctrl, 2=ttbr, 3=dac, 5={24'd0,fsr}, 6=far; all other CRn read 32'd0.
REQ-024 MCR to CRn 0, 4, or 9-15 SHALL have no effect; CRn=5 writes fsr[7:0], CRn=6 writes far.
REQ-025 MCR to CRn=8 SHALL pulse o_tlb_inv for one cycle in WR_CP.
REQ-026 WAIT_INV SHALL hold o_cache_inv=1 until i_cache_inv_done=1, then go to DONE; done in same cycle as entry allowed.
REQ-027 DONE SHALL assert o_cp_done=1 for exactly one cycle and return to IDLE.
REQ-028 Latency from acceptance edge to o_cp_done: MCR (CRn!=7) 3 cycles, MRC 2 cycles, other 1 cycle.
REQ-029 i_fault_valid=1 SHALL load fsr<=i_fsr, far<=i_far in any state; if coincident with WR_CP write to CRn 5/6, the fault capture wins.
REQ-030 All request outputs (o_reg_rd_en, o_reg_wr_en, o_tlb_inv, o_cache_inv, o_cp_done) SHALL be 0 outside their stated states.

Reset
REQ-031 On i_reset: state=IDLE; ctrl, ttbr, dac, far=0; fsr=0; all request outputs and o_cp_done=0; o_reg_mode=0.
REQ-032 Reset mid-operation SHALL abort immediately with no further register write, inv request or done pulse.

Verification
REQ-033 MCR p15,c2 with Rd=R3 holding 32'h0000_4000 -> rd_en ndx 3 one cycle, o_ttbr=32'h0000_4000, o_cp_done 3 cycles after accept.
REQ-034 MRC p15,c0 to R1 -> o_reg_wr_en with ndx 1, data CP15_ID; o_cp_done 2 cycles after accept; MRC to R15 -> no wr_en.
REQ-035 MCR c7 with i_cache_inv_done delayed 5 cycles -> o_cache_inv high 5 cycles, o_cp_done the cycle after done.
REQ-036 Fault (fsr 8'h05, far 32'hDEAD_0000) coincident with MCR write to c6 -> far=32'hDEAD_0000.
REQ-037 CDP or coprocessor 14 word -> o_cp_done 1 cycle after accept, no register-port or CP15 activity.
REQ-038 i_reset asserted during WAIT_INV -> o_cache_inv=0 and o_cp_done=0 next cycle, state IDLE.
